paula_serial_port: RTL and testbench

Paula UART for the Minimig chipset: implements SERDAT, SERPER and SERDATR, serialises transmit data onto `txd`, deserialises `rxd`, and raises the one-cycle `txint`/`rxint` pulses consumed by the Paula interrupt controller as the TBE (bit 0) and RBF (bit 11) request sources. The RBF status bit is not stored here. It is read back from the controller's `rbfmirror` output, so clearing INTREQ bit 11 clears it.

---
 rtl/paula_serial_port.sv | 256 +++++++++++++++++++++++++
 tb/tb_paula_serial_port.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/paula_serial_port.sv
// rtl/paula_serial_port.sv - Paula UART: SERDAT/SERPER/SERDATR, TX/RX shifters, TBE/RBF pulses
// Define PAULA_SERIAL_RXFILTER_EN for 3-tick majority-vote RX sampling.
module paula_serial_port (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk7_en,
   input  logic [8:1]  reg_address_in,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   input  logic        rbfmirror,
   input  logic        rxd,
   output logic        txd,
   output logic        rxint,
   output logic        txint
);

   localparam logic [8:0] SERDATR_ADDR = 9'h018;
   localparam logic [8:0] SERDAT_ADDR  = 9'h030;
   localparam logic [8:0] SERPER_ADDR  = 9'h032;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   logic [15:0] serper_q, serper_d;
   logic [9:0]  txbuf_q, txbuf_d;
   logic        tbe_q, tbe_d;
   logic        tsre_q, tsre_d;
   logic [9:0]  tx_shift_q, tx_shift_d;
   logic [3:0]  tx_bits_q, tx_bits_d;
   logic [14:0] tx_cnt_q, tx_cnt_d;
   logic        txd_q, txd_d;
   logic        txint_q, txint_d;

   logic [1:0]  sync_q;
   logic        rxd_sync;
   rx_state_t   rx_state_q, rx_state_d;
   logic        rx_prev_q, rx_prev_d;
   logic [14:0] rx_cnt_q, rx_cnt_d;
   logic [3:0]  rx_bits_q, rx_bits_d;
   logic [8:0]  rx_shift_q, rx_shift_d;
   logic        rx_long_q, rx_long_d;
   logic [9:0]  rxbuf_q, rxbuf_d;
   logic        ovrun_q, ovrun_d;
   logic        rxint_q, rxint_d;

   logic        wr_serdat, wr_serper, rd_serdatr;
   logic [14:0] half_p, half_m1, start_load;
   logic        start_now, rx_bit, rx_complete;

   assign wr_serdat  = (reg_address_in == SERDAT_ADDR[8:1]);
   assign wr_serper  = (reg_address_in == SERPER_ADDR[8:1]);
   assign rd_serdatr = (reg_address_in == SERDATR_ADDR[8:1]);

   assign rxd_sync = sync_q[1];

   // (PER+1)/2 without a 16-bit intermediate
   assign half_p    = {1'b0, serper_q[14:1]} + {14'd0, serper_q[0]};
   assign half_m1   = half_p - 15'd1;
   assign start_now = (half_p == 15'd0);

`ifdef PAULA_SERIAL_RXFILTER_EN
   logic rx_prev2_q;
   logic filt_on;
   assign filt_on    = (serper_q[14:0] >= 15'd3);
   // Counting starts one tick later so the vote completes at sample+1.
   assign start_load = filt_on ? half_p : half_m1;
   assign rx_bit     = filt_on ? ((rx_prev2_q & rx_prev_q) | (rx_prev2_q & rxd_sync) |
                                  (rx_prev_q & rxd_sync))
                               : rxd_sync;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_prev2_q <= 1'b1;
      end else if (clk7_en) begin
         rx_prev2_q <= rx_prev_q;
      end
   end
`else
   assign start_load = half_m1;
   assign rx_bit     = rxd_sync;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rxd};
      end
   end

   always_comb begin
      serper_d   = serper_q;
      txbuf_d    = txbuf_q;
      tbe_d      = tbe_q;
      tsre_d     = tsre_q;
      tx_shift_d = tx_shift_q;
      tx_bits_d  = tx_bits_q;
      tx_cnt_d   = tx_cnt_q;
      txd_d      = txd_q;
      txint_d    = 1'b0;

      if (!tbe_q && tsre_q) begin
         tx_shift_d = txbuf_q;
         tx_bits_d  = serper_q[15] ? 4'd10 : 4'd9;
         tx_cnt_d   = serper_q[14:0];
         tbe_d      = 1'b1;
         tsre_d     = 1'b0;
         txint_d    = 1'b1;
         txd_d      = 1'b0;
      end else if (!tsre_q) begin
         if (tx_cnt_q == 15'd0) begin
            tx_cnt_d = serper_q[14:0];
            if (tx_bits_q == 4'd0) begin
               txd_d  = 1'b1;
               tsre_d = 1'b1;
            end else begin
               txd_d      = tx_shift_q[0];
               tx_shift_d = {1'b0, tx_shift_q[9:1]};
               tx_bits_d  = tx_bits_q - 4'd1;
            end
         end else begin
            tx_cnt_d = tx_cnt_q - 15'd1;
         end
      end

      // A write on the transfer tick re-arms txbuf after the shifter took the old word.
      if (wr_serdat) begin
         txbuf_d = data_in[9:0];
         tbe_d   = 1'b0;
      end
      if (wr_serper) begin
         serper_d = data_in;
      end
   end

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_prev_d   = rxd_sync;
      rx_cnt_d    = rx_cnt_q;
      rx_bits_d   = rx_bits_q;
      rx_shift_d  = rx_shift_q;
      rx_long_d   = rx_long_q;
      rxbuf_d     = rxbuf_q;
      rxint_d     = 1'b0;
      rx_complete = 1'b0;

      case (rx_state_q)
         RX_IDLE: begin
            if (rx_prev_q && !rxd_sync) begin
               rx_long_d = serper_q[15];
               rx_bits_d = serper_q[15] ? 4'd9 : 4'd8;
               if (start_now) begin
                  rx_state_d = RX_DATA;
                  rx_cnt_d   = serper_q[14:0];
               end else begin
                  rx_state_d = RX_START;
                  rx_cnt_d   = start_load;
               end
            end
         end
         RX_START: begin
            if (rx_cnt_q == 15'd0) begin
               if (rx_bit) begin
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_state_d = RX_DATA;
                  rx_cnt_d   = serper_q[14:0];
               end
            end else begin
               rx_cnt_d = rx_cnt_q - 15'd1;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == 15'd0) begin
               rx_shift_d = {rx_bit, rx_shift_q[8:1]};
               rx_bits_d  = rx_bits_q - 4'd1;
               rx_cnt_d   = serper_q[14:0];
               if (rx_bits_q == 4'd1) begin
                  rx_state_d = RX_STOP;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - 15'd1;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == 15'd0) begin
               rx_complete = 1'b1;
               rxint_d     = 1'b1;
               rx_state_d  = RX_IDLE;
               rxbuf_d     = rx_long_q ? {rx_bit, rx_shift_q}
                                       : {1'b0, rx_bit, rx_shift_q[8:1]};
            end else begin
               rx_cnt_d = rx_cnt_q - 15'd1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase

      ovrun_d = ovrun_q;
      if (rx_complete) begin
         if (rbfmirror) begin
            ovrun_d = 1'b1;
         end
      end else if (!rbfmirror) begin
         ovrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         serper_q   <= 16'd0;
         txbuf_q    <= 10'd0;
         tbe_q      <= 1'b1;
         tsre_q     <= 1'b1;
         tx_shift_q <= 10'd0;
         tx_bits_q  <= 4'd0;
         tx_cnt_q   <= 15'd0;
         txd_q      <= 1'b1;
         txint_q    <= 1'b0;
         rx_state_q <= RX_IDLE;
         rx_prev_q  <= 1'b1;
         rx_cnt_q   <= 15'd0;
         rx_bits_q  <= 4'd0;
         rx_shift_q <= 9'd0;
         rx_long_q  <= 1'b0;
         rxbuf_q    <= 10'd0;
         ovrun_q    <= 1'b0;
         rxint_q    <= 1'b0;
      end else if (clk7_en) begin
         serper_q   <= serper_d;
         txbuf_q    <= txbuf_d;
         tbe_q      <= tbe_d;
         tsre_q     <= tsre_d;
         tx_shift_q <= tx_shift_d;
         tx_bits_q  <= tx_bits_d;
         tx_cnt_q   <= tx_cnt_d;
         txd_q      <= txd_d;
         txint_q    <= txint_d;
         rx_state_q <= rx_state_d;
         rx_prev_q  <= rx_prev_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bits_q  <= rx_bits_d;
         rx_shift_q <= rx_shift_d;
         rx_long_q  <= rx_long_d;
         rxbuf_q    <= rxbuf_d;
         ovrun_q    <= ovrun_d;
         rxint_q    <= rxint_d;
      end
   end

   assign data_out = rd_serdatr ? {ovrun_q, rbfmirror, tbe_q, tsre_q, rxd_sync, 1'b0, rxbuf_q}
                                : 16'd0;
   assign txd   = txd_q;
   assign txint = txint_q;
   assign rxint = rxint_q;

endmodule

// File: tb/tb_paula_serial_port.sv
// tb/tb_paula_serial_port.sv - self-checking bench for paula_serial_port
module tb_paula_serial_port;

   logic        clk;
   logic        reset;
   logic        clk7_en;
   logic [8:1]  reg_address_in;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        rbfmirror;
   logic        rxd;
   logic        txd;
   logic        rxint;
   logic        txint;

   int vectors = 0;
   int errors  = 0;

   localparam logic [8:1] A_SERDATR = 8'h0C;
   localparam logic [8:1] A_SERDAT  = 8'h18;
   localparam logic [8:1] A_SERPER  = 8'h19;
   localparam logic [8:1] A_NONE    = 8'h00;

`ifdef PAULA_SERIAL_RXFILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   paula_serial_port dut (
      .clk            (clk),
      .reset          (reset),
      .clk7_en        (clk7_en),
      .reg_address_in (reg_address_in),
      .data_in        (data_in),
      .data_out       (data_out),
      .rbfmirror      (rbfmirror),
      .rxd            (rxd),
      .txd            (txd),
      .rxint          (rxint),
      .txint          (txint)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // one tick every fourth clk keeps the 2-flop synchroniser inside a tick
   initial begin
      clk7_en = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         clk7_en = 1'b1;
         @(negedge clk);
         clk7_en = 1'b0;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic do_tick();
      @(posedge clk);
      while (!clk7_en) @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [8:1] addr, input logic [15:0] val);
      reg_address_in = addr;
      data_in        = val;
      do_tick();
      reg_address_in = A_SERDATR;
   endtask

   // txd level expected k ticks after the transfer tick (k=1 is the transfer tick)
   function automatic logic exp_txd(input logic [9:0] w, input bit lng, input int p, input int k);
      int idx;
      int nb;
      idx = (k - 1) / p;
      nb  = lng ? 10 : 9;
      if (idx == 0) return 1'b0;
      if (idx <= nb) return w[idx-1];
      return 1'b1;
   endfunction

   task automatic check_tx_frame(input logic [9:0] w, input bit lng, input int p);
      int nb;
      int last;
      logic e;
      nb   = lng ? 10 : 9;
      last = p * (nb + 1);
      for (int k = 1; k <= last + 2; k++) begin
         do_tick();
         e = exp_txd(w, lng, p, k);
         vectors++;
         if (txd !== e) begin
            errors++;
            $display("FAIL tx_txd w=%h p=%0d k=%0d: got %b expected %b", w, p, k, txd, e);
         end
         vectors++;
         if (txint !== (k == 1)) begin
            errors++;
            $display("FAIL tx_txint k=%0d: got %b expected %b", k, txint, (k == 1));
         end
         if (k == last) begin
            vectors++;
            if (data_out[12] !== 1'b0) begin
               errors++;
               $display("FAIL tx_tsre_busy k=%0d: got %b expected 0", k, data_out[12]);
            end
         end
         if (k == last + 1) begin
            vectors++;
            if (data_out[12] !== 1'b1) begin
               errors++;
               $display("FAIL tx_tsre_done k=%0d: got %b expected 1", k, data_out[12]);
            end
         end
      end
   endtask

   task automatic send_rx(input logic [8:0] d, input bit lng, input int p, input bit exp_ovr);
      int n;
      int when_int;
      int idx;
      logic [9:0] exp_buf;
      n        = lng ? 9 : 8;
      when_int = p / 2 + p * (n + 1) + ((FILT && p >= 4) ? 1 : 0);
      exp_buf  = lng ? (10'h200 | {1'b0, d}) : (10'h100 | {2'b00, d[7:0]});
      write_reg(A_SERPER, {lng, 15'(p - 1)});
      for (int j = 0; j < p * (n + 4); j++) begin
         idx = j / p;
         if (idx == 0) rxd = 1'b0;
         else if (idx <= n) rxd = d[idx-1];
         else rxd = 1'b1;
         do_tick();
         vectors++;
         if (rxint !== (j == when_int)) begin
            errors++;
            $display("FAIL rx_rxint d=%h p=%0d j=%0d: got %b expected %b", d, p, j, rxint, (j == when_int));
         end
         if (j == when_int) begin
            vectors++;
            if (data_out[9:0] !== exp_buf) begin
               errors++;
               $display("FAIL rx_buf: got %h expected %h", data_out[9:0], exp_buf);
            end
            vectors++;
            if (data_out[15] !== exp_ovr) begin
               errors++;
               $display("FAIL rx_ovrun: got %b expected %b", data_out[15], exp_ovr);
            end
         end
      end
   endtask

   task automatic test_reset();
      #1;
      vectors++;
      if (txd !== 1'b1 || txint !== 1'b0 || rxint !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got txd=%b txint=%b rxint=%b expected 1 0 0", txd, txint, rxint);
      end
      vectors++;
      if (data_out !== 16'h3800) begin
         errors++;
         $display("FAIL reset_serdatr: got %h expected 3800", data_out);
      end
      @(negedge clk);
      reset = 1'b0;
      do_tick();
      vectors++;
      if (data_out !== 16'h3800) begin
         errors++;
         $display("FAIL post_reset_serdatr: got %h expected 3800", data_out);
      end
      reg_address_in = A_NONE;
      #1;
      vectors++;
      if (data_out !== 16'h0000) begin
         errors++;
         $display("FAIL unaddressed_read: got %h expected 0000", data_out);
      end
      reg_address_in = A_SERDATR;
   endtask

   task automatic test_tx_basic();
      write_reg(A_SERPER, 16'd3);
      write_reg(A_SERDAT, 16'h0155);
      check_tx_frame(10'h155, 1'b0, 4);
   endtask

   task automatic test_tx_random();
      int per;
      bit lng;
      logic [9:0] w;
      for (int i = 0; i < 4; i++) begin
         per = (i == 0) ? 0 : $urandom_range(1, 5);
         lng = 1'($urandom_range(0, 1));
         w   = 10'($urandom);
         write_reg(A_SERPER, {lng, 15'(per)});
         write_reg(A_SERDAT, {6'd0, w});
         check_tx_frame(w, lng, per + 1);
      end
   endtask

   task automatic test_rx_basic();
      send_rx(9'h03C, 1'b0, 8, 1'b0);
   endtask

   task automatic test_rx_overrun();
      rbfmirror = 1'b1;
      send_rx(9'($urandom), 1'b0, 8, 1'b1);
      vectors++;
      if (data_out[14] !== 1'b1) begin
         errors++;
         $display("FAIL rbf_mirror: got %b expected 1", data_out[14]);
      end
      rbfmirror = 1'b0;
      do_tick();
      vectors++;
      if (data_out[15] !== 1'b0) begin
         errors++;
         $display("FAIL ovrun_clear: got %b expected 0", data_out[15]);
      end
   endtask

   task automatic test_rx_glitch();
      write_reg(A_SERPER, 16'd7);
      rxd = 1'b0;
      do_tick();
      do_tick();
      rxd = 1'b1;
      for (int j = 0; j < 24; j++) begin
         do_tick();
         vectors++;
         if (rxint !== 1'b0) begin
            errors++;
            $display("FAIL glitch_rxint j=%0d: got %b expected 0", j, rxint);
         end
      end
      send_rx(9'h0A5, 1'b0, 8, 1'b0);
   endtask

   task automatic test_rx_random();
      for (int i = 0; i < 3; i++) begin
         send_rx(9'($urandom), 1'($urandom_range(0, 1)), $urandom_range(4, 10), 1'b0);
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] a, b, c;
      logic e;
      a = 10'($urandom) & 10'h1FF;
      c = 10'($urandom) & 10'h1FF;
      b = c ^ 10'h155;
      write_reg(A_SERPER, 16'd3);
      reg_address_in = A_SERDAT;
      data_in = {6'd0, a};
      do_tick();
      data_in = {6'd0, b};
      for (int k = 1; k <= 83; k++) begin
         if (k == 2) data_in = {6'd0, c};
         if (k == 3) reg_address_in = A_SERDATR;
         do_tick();
         e = (k <= 41) ? exp_txd(a, 1'b0, 4, k) : exp_txd(c, 1'b0, 4, k - 41);
         vectors++;
         if (txd !== e) begin
            errors++;
            $display("FAIL b2b_txd k=%0d: got %b expected %b", k, txd, e);
         end
         vectors++;
         if (txint !== (k == 1 || k == 42)) begin
            errors++;
            $display("FAIL b2b_txint k=%0d: got %b expected %b", k, txint, (k == 1 || k == 42));
         end
         if (k == 10) begin
            vectors++;
            if (data_out[13] !== 1'b0) begin
               errors++;
               $display("FAIL b2b_tbe_held: got %b expected 0", data_out[13]);
            end
         end
         if (k == 42) begin
            vectors++;
            if (data_out[13] !== 1'b1) begin
               errors++;
               $display("FAIL b2b_tbe_after: got %b expected 1", data_out[13]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_tx();
      write_reg(A_SERPER, 16'd3);
      write_reg(A_SERDAT, 16'h00AA);
      repeat (10) do_tick();
      reset = 1'b1;
      #1;
      vectors++;
      if (txd !== 1'b1 || txint !== 1'b0) begin
         errors++;
         $display("FAIL midtx_reset_txd: got txd=%b txint=%b expected 1 0", txd, txint);
      end
      vectors++;
      if (data_out !== 16'h3800) begin
         errors++;
         $display("FAIL midtx_reset_serdatr: got %h expected 3800", data_out);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int j = 0; j < 50; j++) begin
         do_tick();
         vectors++;
         if (txd !== 1'b1 || txint !== 1'b0) begin
            errors++;
            $display("FAIL midtx_idle j=%0d: got txd=%b txint=%b expected 1 0", j, txd, txint);
         end
      end
   endtask

   initial begin
      reset          = 1'b1;
      rxd            = 1'b1;
      rbfmirror      = 1'b0;
      reg_address_in = A_SERDATR;
      data_in        = 16'd0;
      repeat (3) @(posedge clk);
      test_reset();
      test_tx_basic();
      test_tx_random();
      test_rx_basic();
      test_rx_overrun();
      test_rx_glitch();
      test_rx_random();
      test_back_to_back();
      test_reset_mid_tx();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
